// File: rtl/cflog_writer.sv
// CF-Log appender: buffers (src,dst) branch pairs in a small FIFO and streams them
// as two 16-bit words into the log region, requesting a flush when the log fills.
module cflog_writer #(
    parameter logic [15:0] LOG_min    = 16'h01B0,
    parameter logic [15:0] LOG_SIZE   = 16'h0080,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ev_valid,
    input  logic [15:0] ev_src,
    input  logic [15:0] ev_dst,
    output logic        log_wr_en,
    output logic [15:0] log_wr_addr,
    output logic [15:0] log_wr_data,
    input  logic        log_wr_ready,
    output logic [15:0] log_ptr,
    output logic        log_full,
    output logic        flush_req,
    input  logic        flush_ack,
    output logic        overflow
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [15:0] src;
        logic [15:0] dst;
    } pair_t;

    typedef enum logic [1:0] {IDLE, WR_SRC, WR_DST, FULL} state_t;

    pair_t            fifo_q [FIFO_DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [15:0]      ptr_q, ptr_d;
    logic             ovf_q, ovf_d;
    logic             fifo_full, push, pop;
    pair_t            head;

    assign head      = fifo_q[rd_q];
    assign fifo_full = (cnt_q == CW'(FIFO_DEPTH));
    assign pop       = (state_q == WR_DST) && log_wr_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push      = ev_valid && (!fifo_full || pop);
    assign log_ptr   = ptr_q;
    assign log_full  = (ptr_q == LOG_SIZE);
    assign overflow  = ovf_q;

    always_comb begin
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        rd_d  = pop  ? rd_q + AW'(1) : rd_q;
        wr_d  = push ? wr_q + AW'(1) : wr_q;
        ovf_d = ovf_q | (ev_valid & !push);
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        log_wr_en   = 1'b0;
        log_wr_addr = LOG_min;
        log_wr_data = 16'h0000;
        flush_req   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cnt_q != '0 && !log_full) state_d = WR_SRC;
            end
            WR_SRC: begin
                log_wr_en   = 1'b1;
                log_wr_addr = LOG_min + {ptr_q[14:0], 1'b0};
                log_wr_data = head.src;
                if (log_wr_ready) begin
                    ptr_d   = ptr_q + 16'd1;
                    state_d = WR_DST;
                end
            end
            WR_DST: begin
                log_wr_en   = 1'b1;
                log_wr_addr = LOG_min + {ptr_q[14:0], 1'b0};
                log_wr_data = head.dst;
                if (log_wr_ready) begin
                    ptr_d = ptr_q + 16'd1;
                    if (ptr_d == LOG_SIZE)  state_d = FULL;
                    else if (cnt_d != '0)   state_d = WR_SRC;
                    else                    state_d = IDLE;
                end
            end
            FULL: begin
                flush_req = 1'b1;
                if (flush_ack) begin
                    ptr_d   = 16'h0000;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= 16'h0000;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ovf_q   <= ovf_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_q] <= '{src: ev_src, dst: ev_dst};
    end
endmodule

// File: tb/tb_cflog_writer.sv
// Randomized and directed bench for cflog_writer with a queue-based scoreboard.
module tb_cflog_writer;
    localparam logic [15:0] LMIN  = 16'h01B0;
    localparam int          LSIZE = 128;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0, reset_n = 1'b0, ev_valid = 1'b0;
    logic        log_wr_ready = 1'b0, flush_ack = 1'b0;
    logic [15:0] ev_src = '0, ev_dst = '0;
    logic        log_wr_en, log_full, flush_req, overflow;
    logic [15:0] log_wr_addr, log_wr_data, log_ptr;

    cflog_writer #(.LOG_min(LMIN), .LOG_SIZE(16'(LSIZE)), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .ev_valid(ev_valid), .ev_src(ev_src), .ev_dst(ev_dst),
        .log_wr_en(log_wr_en), .log_wr_addr(log_wr_addr), .log_wr_data(log_wr_data),
        .log_wr_ready(log_wr_ready), .log_ptr(log_ptr), .log_full(log_full),
        .flush_req(flush_req), .flush_ack(flush_ack), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         wq[$];
    int          chk = 0, err = 0;
    int          nacc = 0, ncommit = 0, occ = 0, mptr = 0;
    bit          exp_ovf = 0, mon_en = 0, stall_v = 0;
    logic [15:0] stall_addr, stall_data;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: the k-th accepted pair lands at word 2k mod LOG_SIZE, since each
    // flush rewinds to the base and pairs never straddle a flush.
    always @(negedge clk) begin
        bit  commit, pop, full_now;
        wr_t w;
        if (mon_en) begin
            full_now = (mptr == LSIZE);
            check("log_ptr", 32'(log_ptr), 32'(mptr));
            check("log_full", 32'(log_full), 32'(full_now));
            check("flush_req", 32'(flush_req), 32'(full_now));
            check("overflow", 32'(overflow), 32'(exp_ovf));
            if (full_now) check("no_write_when_full", 32'(log_wr_en), 0);
            if (stall_v) begin
                check("hold_en", 32'(log_wr_en), 1);
                check("hold_addr", 32'(log_wr_addr), 32'(stall_addr));
                check("hold_data", 32'(log_wr_data), 32'(stall_data));
            end
            stall_v    = log_wr_en && !log_wr_ready && reset_n;
            stall_addr = log_wr_addr;
            stall_data = log_wr_data;
            commit     = log_wr_en && log_wr_ready;
            if (!reset_n) begin
                wq.delete();
                nacc = 0; ncommit = 0; occ = 0; mptr = 0; exp_ovf = 0; stall_v = 0;
            end else begin
                pop = commit && (ncommit % 2 == 1);
                if (commit) begin
                    if (wq.size() == 0) begin
                        chk++; err++;
                        $display("FAIL unexpected_write actual=%h@%h required=none", log_wr_data, log_wr_addr);
                    end else begin
                        w = wq.pop_front();
                        check("wr_addr", 32'(log_wr_addr), 32'(w.addr));
                        check("wr_data", 32'(log_wr_data), 32'(w.data));
                    end
                    ncommit++;
                    mptr++;
                end
                if (flush_ack && full_now) mptr = 0;
                if (ev_valid) begin
                    if (occ < DEPTH || pop) begin
                        wq.push_back('{addr: LMIN + 16'((2 * nacc) % LSIZE) * 16'd2, data: ev_src});
                        wq.push_back('{addr: LMIN + 16'((2 * nacc + 1) % LSIZE) * 16'd2, data: ev_dst});
                        nacc++;
                        occ++;
                    end else begin
                        exp_ovf = 1;
                    end
                end
                if (pop) occ--;
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic sample;
        @(negedge clk); #1;
    endtask

    task automatic realign;
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0; ev_valid = 1'b0; flush_ack = 1'b0;
        cyc(2);
        reset_n = 1'b1;
    endtask

    task automatic send(logic [15:0] s, logic [15:0] d);
        ev_valid = 1'b1; ev_src = s; ev_dst = d;
        cyc(1);
        ev_valid = 1'b0;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((wq.size() != 0 || log_wr_en) && n < budget) begin cyc(1); n++; end
        check("drain_done", 32'(wq.size()), 0);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        cyc(2);
        mon_en = 1;
        reset_n = 1'b1;
        sample;
        check("rst_en", 32'(log_wr_en), 0);
        check("rst_addr", 32'(log_wr_addr), 32'(LMIN));
        check("rst_data", 32'(log_wr_data), 0);
        realign;

        // Single event, latency with ready held high.
        log_wr_ready = 1'b1;
        send(16'hE010, 16'hE200);
        sample; check("lat_idle_en", 32'(log_wr_en), 0);
        sample; check("lat_src_en", 32'(log_wr_en), 1);
        check("lat_src_addr", 32'(log_wr_addr), 32'h01B0);
        check("lat_src_data", 32'(log_wr_data), 32'hE010);
        sample; check("lat_dst_addr", 32'(log_wr_addr), 32'h01B2);
        check("lat_dst_data", 32'(log_wr_data), 32'hE200);
        sample; check("lat_back_idle", 32'(log_wr_en), 0);
        check("lat_ptr", 32'(log_ptr), 2);
        realign;

        // Back-pressure in WR_SRC.
        log_wr_ready = 1'b0;
        send(16'h1234, 16'h5678);
        cyc(6);
        sample; check("bp_en", 32'(log_wr_en), 1);
        check("bp_ptr", 32'(log_ptr), 2);
        realign;
        log_wr_ready = 1'b1;
        cyc(4);
        check("bp_ptr_after", 32'(log_ptr), 4);

        // Fill the log, then buffer/overflow while FULL.
        do_reset;
        log_wr_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            send(16'($urandom), 16'($urandom));
            cyc(1);
        end
        n = 0;
        while (!flush_req && n < 200) begin cyc(1); n++; end
        check("fill_flush_req", 32'(flush_req), 1);
        check("fill_log_full", 32'(log_full), 1);
        send(16'hAAAA, 16'hBBBB);
        cyc(3);
        sample; check("full_no_write", 32'(log_wr_en), 0);
        check("full_no_ovf_yet", 32'(overflow), 0);
        realign;
        for (int i = 0; i < 4; i++) send(16'($urandom), 16'($urandom));
        sample; check("full_overflow", 32'(overflow), 1);
        realign;
        flush_ack = 1'b1;
        cyc(1);
        flush_ack = 1'b0;
        drain(50);
        check("ovf_sticky", 32'(overflow), 1);
        check("post_flush_ptr", 32'(log_ptr), 8);

        // FIFO full while WR_DST pops: same-cycle push must be accepted.
        do_reset;
        log_wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'(16'h3000 + i), 16'(16'h4000 + i));
        cyc(3);
        log_wr_ready = 1'b1;
        cyc(1);
        send(16'h3333, 16'h4444);
        sample; check("pushpop_no_ovf", 32'(overflow), 0);
        realign;
        drain(40);

        // Reset in the middle of WR_DST abandons everything.
        do_reset;
        log_wr_ready = 1'b1;
        send(16'h5000, 16'h6000);
        send(16'h5001, 16'h6001);
        cyc(1);
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        sample;
        check("midrst_en", 32'(log_wr_en), 0);
        check("midrst_ptr", 32'(log_ptr), 0);
        check("midrst_addr", 32'(log_wr_addr), 32'(LMIN));
        check("midrst_data", 32'(log_wr_data), 0);
        realign;
        cyc(5);
        check("midrst_fifo_empty", 32'(log_wr_en), 0);

        // Random traffic with random stalls and stray acknowledges.
        do_reset;
        for (int i = 0; i < 1500; i++) begin
            ev_valid     = ($urandom_range(99) < 45);
            ev_src       = 16'($urandom);
            ev_dst       = 16'($urandom);
            log_wr_ready = ($urandom_range(99) < 70);
            flush_ack    = ($urandom_range(99) < 15);
            cyc(1);
        end
        ev_valid = 1'b0; log_wr_ready = 1'b1; flush_ack = 1'b1;
        drain(400);
        flush_ack = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule
